tone_note_decoder: RTL and testbench
====================================

# tone_note_decoder

Receive-side counterpart of the music-box tone generator: measures the period of an incoming square-wave tone (e.g. a generator's `spk1` looped back or an external pin) and classifies it as one of the 14 notes C4–B5, silence, or out-of-band. It sits between an asynchronous tone pin and downstream display or scoring logic. It reports a debounced note code, a lock flag and a one-cycle change strobe.

## Interface
- `CLK_HZ`, 50000000: reference clock frequency; nominal periods derive from it exactly as the generator derives its half-period counts.
- `STABLE_N`, 4: consecutive same-class periods required to lock (range 1–15).
- `TIMEOUT`, 500000: cycles without a rising edge before silence is declared (must be < 2^20).
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-high.
- `tone_in` in 1: asynchronous square-wave input.
- `note` out 4: locked note code. 0 = silence, 1–7 = C4..B4, 8–14 = C5..B5, 15 = out-of-band.
- `locked` out 1: `note` is backed by STABLE_N matching periods.
- `note_valid` out 1: one-cycle pulse whenever `note` or `locked` changes.
- `period` out 20: last measured full period in clk cycles.

## Operation
- Input path: 2-FF synchronizer on `tone_in`, then rising-edge detect. Only rising edges are used.
- Edge counter, 20 bits:
  - Counts cycles since the last detected edge and saturates at TIMEOUT.
  - On each edge after the first, `period` is loaded with the exact cycle distance to the previous edge.
  - The first edge after reset or silence only arms the counter and produces no period.
- Nominal periods:
  - H_k = CLK_HZ/f_k/2 (integer division, f = 261, 293, 329, 349, 392, 440, 493).
  - Octave-4 period = 2·H_k.
  - Octave-5 period = 2·(H_k/2).
- Classification:
  - Class boundaries are the integer midpoints between adjacent nominal periods.
  - A period above P_C4 + P_C4/16 or below P_B5 − P_B5/16 is class 15.
- State machine:
  - SILENT (reset state): `note` = 0, `locked` = 0. First edge → ACQUIRE with the counter armed.
  - ACQUIRE: per new period, if the class equals the candidate then stable_cnt++, else candidate = class and stable_cnt = 1. When stable_cnt reaches STABLE_N → LOCKED, `note` = candidate, `locked` = 1, `note_valid` pulses.
  - LOCKED: a matching period causes no output change. The first mismatching period sends the block to ACQUIRE with candidate = new class and stable_cnt = 1. `locked` drops (with a `note_valid` pulse) while `note` holds its old value until relock.
  - Any state: when the counter reaches TIMEOUT → SILENT, `note` = 0, `locked` = 0. `note_valid` pulses only if an output changed.

## Timing
- Reset values: `note` = 0, `locked` = 0, `note_valid` = 0, `period` = 0. Internal counters and candidate are also 0, and the FSM is in SILENT. All are cleared asynchronously on `rst` assertion, including mid-measurement.
- Latency from a `tone_in` rising edge to the `period` update is 3 clk cycles (2 sync + 1 detect/capture).
- Class result is registered 1 cycle after the `period` update.
- `note`, `locked` and `note_valid` update 1 cycle after the class result, 5 cycles after the pin edge.
- Timeout asserts exactly TIMEOUT cycles after the last detected edge.
- If an edge and counter == TIMEOUT occur in the same cycle, timeout wins and that edge is treated as a first (arming) edge.
- The counter saturates at TIMEOUT and never wraps.
- With STABLE_N = 1, each classified period updates immediately.

## Structure
- Shared package `tone_pkg`:
  - note-code localparams (`NOTE_SILENT` = 0, `NOTE_C4` = 1 … `NOTE_B5` = 14, `NOTE_OOB` = 15);
  - frequency list;
  - a function computing nominal period and class boundaries from CLK_HZ.
- The generator side reuses the same package for its counts.
- FSM state enum lives locally in the module.
- Sub-module `tone_sync_edge`: 2-FF synchronizer plus rising-edge pulse, with async active-high reset to 0.

## Test plan
- 440 Hz generator-style input (half-period 56818, period 113636), defaults → `note` = 6, `locked` = 1 and one `note_valid` pulse, 5 cycles after the 5th rising edge; `period` = 113636.
- Lock F5 (period 71632), then switch to A5 (period 56818) → `locked` drops after the first A5 period with `note` still 11; relock to `note` = 13 after 4 A5 periods; two `note_valid` pulses in total.
- Lock A4, then hold `tone_in` low → exactly 500000 cycles after the last detected edge: `note` = 0, `locked` = 0, one `note_valid` pulse. The next edge produces no `period` update.
- Steady 20000-cycle period (2.5 kHz) → `note` = 15, `locked` = 1 after 4 periods.
- A4 periods alternating 112500/114800 (±1%) → locks to `note` = 6 with no spurious `note_valid`.
- Assert `rst` mid-lock for 1 cycle, asynchronously → all outputs 0 immediately. After release, the first edge yields no period, and lock returns after STABLE_N+1 edges.

Source files
------------

// File: rtl/tone_pkg.sv
// Shared tone definitions for the music-box generator and the tone decoder.
// Holds the note-code constants, the seven base frequencies, and constant
// functions that derive nominal periods and classification boundaries
// from the reference clock frequency.
package tone_pkg;

  localparam logic [3:0] NOTE_SILENT = 4'd0;
  localparam logic [3:0] NOTE_C4     = 4'd1;
  localparam logic [3:0] NOTE_D4     = 4'd2;
  localparam logic [3:0] NOTE_E4     = 4'd3;
  localparam logic [3:0] NOTE_F4     = 4'd4;
  localparam logic [3:0] NOTE_G4     = 4'd5;
  localparam logic [3:0] NOTE_A4     = 4'd6;
  localparam logic [3:0] NOTE_B4     = 4'd7;
  localparam logic [3:0] NOTE_C5     = 4'd8;
  localparam logic [3:0] NOTE_D5     = 4'd9;
  localparam logic [3:0] NOTE_E5     = 4'd10;
  localparam logic [3:0] NOTE_F5     = 4'd11;
  localparam logic [3:0] NOTE_G5     = 4'd12;
  localparam logic [3:0] NOTE_A5     = 4'd13;
  localparam logic [3:0] NOTE_B5     = 4'd14;
  localparam logic [3:0] NOTE_OOB    = 4'd15;

  localparam int unsigned NUM_TONES = 7;

  // Octave-4 frequencies in Hz, C through B.
  function automatic int unsigned tone_freq(int unsigned idx);
    int unsigned f;
    case (idx)
      32'd0:   f = 261;
      32'd1:   f = 293;
      32'd2:   f = 329;
      32'd3:   f = 349;
      32'd4:   f = 392;
      32'd5:   f = 440;
      default: f = 493;
    endcase
    return f;
  endfunction

  // Generator half-period count for tone idx.
  function automatic int unsigned half_count(int unsigned clk_hz, int unsigned idx);
    return clk_hz / tone_freq(idx) / 2;
  endfunction

  // Full period in clk cycles for note code 1..14. Octave 5 halves the
  // half-period count with truncation, exactly as the generator does.
  function automatic int unsigned nominal_period(int unsigned clk_hz, int unsigned code);
    int unsigned h;
    h = half_count(clk_hz, (code - 1) % NUM_TONES);
    if (code <= NUM_TONES) return 2 * h;
    return 2 * (h / 2);
  endfunction

  // Boundary between code and code+1 (periods strictly decrease with code).
  function automatic int unsigned class_bound(int unsigned clk_hz, int unsigned code);
    return (nominal_period(clk_hz, code) + nominal_period(clk_hz, code + 1)) / 2;
  endfunction

  function automatic int unsigned oob_high(int unsigned clk_hz);
    int unsigned p;
    p = nominal_period(clk_hz, 32'(NOTE_C4));
    return p + p / 16;
  endfunction

  function automatic int unsigned oob_low(int unsigned clk_hz);
    int unsigned p;
    p = nominal_period(clk_hz, 32'(NOTE_B5));
    return p - p / 16;
  endfunction

endpackage

// File: rtl/tone_sync_edge.sv
// Two-flop synchronizer for an asynchronous pin followed by a rising-edge
// detector. rise is a one-cycle pulse, high in the cycle after the second
// synchronizer stage first sees the pin high.
//   clk  in  : system clock
//   rst  in  : asynchronous active-high reset
//   din  in  : asynchronous input
//   rise out : rising-edge pulse
module tone_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic s1, s2, s3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

endmodule

// File: rtl/tone_note_decoder.sv
// Measures the period of an incoming square-wave tone and classifies it as
// one of the notes C4..B5, silence, or out-of-band, with debounced locking.
//   clk        in  : system clock
//   rst        in  : asynchronous active-high reset
//   tone_in    in  : asynchronous tone pin
//   note       out : locked note code (0 silence, 1..14 C4..B5, 15 out-of-band)
//   locked     out : note backed by STABLE_N matching periods
//   note_valid out : one-cycle pulse when note or locked changes
//   period     out : last measured rising-to-rising distance in clk cycles
//
// state      | meaning
// -----------+--------------------------------------------------------
// ST_SILENT  | no tone; note = 0, waiting for the counter to be armed
// ST_ACQUIRE | counting consecutive periods of the candidate class
// ST_LOCKED  | note is valid; first mismatching period drops the lock
module tone_note_decoder import tone_pkg::*; #(
  parameter int unsigned CLK_HZ   = 50000000,
  parameter int unsigned STABLE_N = 4,
  parameter int unsigned TIMEOUT  = 500000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tone_in,
  output logic [3:0]  note,
  output logic        locked,
  output logic        note_valid,
  output logic [19:0] period
);

  localparam logic [1:0] ST_SILENT  = 2'd0;
  localparam logic [1:0] ST_ACQUIRE = 2'd1;
  localparam logic [1:0] ST_LOCKED  = 2'd2;

  localparam logic [19:0] TIMEOUT_C = 20'(TIMEOUT);
  localparam logic [19:0] OOB_HI    = 20'(oob_high(CLK_HZ));
  localparam logic [19:0] OOB_LO    = 20'(oob_low(CLK_HZ));
  localparam logic [3:0]  STABLE_C  = 4'(STABLE_N);

  logic        rise;
  logic        timeout;
  logic        armed;
  logic [19:0] cnt;
  logic        period_vld;
  logic [12:0] at_or_below;
  logic [3:0]  cls_c;
  logic [3:0]  cls;
  logic        cls_vld;
  logic [1:0]  state;
  logic [3:0]  cand;
  logic [3:0]  stable_cnt;
  logic [3:0]  stable_nxt;

  tone_sync_edge u_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (tone_in),
    .rise (rise)
  );

  assign timeout = (cnt == TIMEOUT_C);

  // cnt holds the number of cycles since the last captured edge, so at the
  // next edge it equals the period directly. A timeout in the same cycle as
  // an edge wins: the edge only re-arms.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      armed      <= 1'b0;
      period     <= '0;
      period_vld <= 1'b0;
    end else begin
      period_vld <= 1'b0;
      if (timeout) begin
        armed <= rise;
        if (rise) cnt <= 20'd1;
      end else begin
        cnt <= rise ? 20'd1 : cnt + 20'd1;
        if (rise) begin
          armed <= 1'b1;
          if (armed) begin
            period     <= cnt;
            period_vld <= 1'b1;
          end
        end
      end
    end
  end

  // Boundaries descend with code, so the matches form a thermometer code
  // and their population count is the offset from C4.
  for (genvar k = 0; k < 13; k++) begin : g_bound
    localparam logic [19:0] BOUND = 20'(class_bound(CLK_HZ, k + 1));
    assign at_or_below[k] = (period <= BOUND);
  end

  always_comb begin
    cls_c = NOTE_C4 + 4'($countones(at_or_below));
    if (period > OOB_HI || period < OOB_LO) cls_c = NOTE_OOB;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cls     <= NOTE_SILENT;
      cls_vld <= 1'b0;
    end else begin
      cls     <= cls_c;
      cls_vld <= period_vld;
    end
  end

  assign stable_nxt = (cls == cand) ? stable_cnt + 4'd1 : 4'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_SILENT;
      cand       <= NOTE_SILENT;
      stable_cnt <= '0;
      note       <= NOTE_SILENT;
      locked     <= 1'b0;
      note_valid <= 1'b0;
    end else begin
      note_valid <= 1'b0;
      if (timeout) begin
        state      <= ST_SILENT;
        cand       <= NOTE_SILENT;
        stable_cnt <= '0;
        note       <= NOTE_SILENT;
        locked     <= 1'b0;
        note_valid <= (note != NOTE_SILENT) || locked;
      end else begin
        case (state)
          ST_SILENT: begin
            if (armed) state <= ST_ACQUIRE;
          end
          ST_ACQUIRE: begin
            if (cls_vld) begin
              cand       <= cls;
              stable_cnt <= stable_nxt;
              if (stable_nxt >= STABLE_C) begin
                state      <= ST_LOCKED;
                note       <= cls;
                locked     <= 1'b1;
                note_valid <= 1'b1;
              end
            end
          end
          ST_LOCKED: begin
            if (cls_vld && cls != note) begin
              cand       <= cls;
              stable_cnt <= 4'd1;
              note_valid <= 1'b1;
              // A single period is already enough to relock.
              if (STABLE_N == 1) begin
                note <= cls;
              end else begin
                state  <= ST_ACQUIRE;
                locked <= 1'b0;
              end
            end
          end
          default: state <= ST_SILENT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tone_note_decoder.sv
// Self-checking bench for tone_note_decoder. A scaled-down clock frequency
// keeps nominal periods in the hundreds of cycles so the run stays short.
module tb_tone_note_decoder;

  localparam int unsigned CLK_HZ   = 200000;
  localparam int unsigned STABLE_N = 4;
  localparam int unsigned TIMEOUT  = 2000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tone_in = 1'b0;
  logic [3:0]  note;
  logic        locked;
  logic        note_valid;
  logic [19:0] period;

  always #5 clk = ~clk;

  tone_note_decoder #(
    .CLK_HZ   (CLK_HZ),
    .STABLE_N (STABLE_N),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tone_in    (tone_in),
    .note       (note),
    .locked     (locked),
    .note_valid (note_valid),
    .period     (period)
  );

  int errors = 0;
  int checks = 0;
  int pulses = 0;

  always @(negedge clk) if (note_valid === 1'b1) pulses++;

  // Reference model state
  bit          armed_m;
  int          gap;
  int          cls_q[$];
  logic [3:0]  note_e;
  logic        locked_e;
  logic [19:0] per_e;
  int          pulses_e;

  function automatic int freq(int idx);
    int f;
    case (idx)
      0: f = 261;
      1: f = 293;
      2: f = 329;
      3: f = 349;
      4: f = 392;
      5: f = 440;
      default: f = 493;
    endcase
    return f;
  endfunction

  function automatic int nom(int code);
    int h;
    h = int'(CLK_HZ) / freq((code - 1) % 7) / 2;
    return (code <= 7) ? 2 * h : 2 * (h / 2);
  endfunction

  // Nearest nominal period; equal distance goes to the shorter period.
  function automatic int classify(int p);
    int hi, lo, best, bestd, d;
    hi = nom(1) + nom(1) / 16;
    lo = nom(14) - nom(14) / 16;
    if (p > hi || p < lo) return 15;
    best = 1;
    bestd = (p > nom(1)) ? p - nom(1) : nom(1) - p;
    for (int c = 2; c <= 14; c++) begin
      d = (p > nom(c)) ? p - nom(c) : nom(c) - p;
      if (d <= bestd) begin
        bestd = d;
        best = c;
      end
    end
    return best;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic silence_m();
    if (note_e != 4'd0 || locked_e) pulses_e++;
    note_e = 4'd0;
    locked_e = 1'b0;
    cls_q.delete();
  endtask

  // Raise tone_in at a falling clock edge and check the pipeline at each
  // stage up to the note update 5 cycles later. Returns 1 ns past n5.
  task automatic edge_step();
    bit         had;
    int         c, run, i;
    logic       nl;
    logic [3:0] nn;
    had = 0;
    tone_in = 1'b1;
    repeat (2) @(negedge clk);
    #1 chk("period_hold", period, per_e);
    @(negedge clk);
    #1;
    if (armed_m && gap >= int'(TIMEOUT)) silence_m();
    else if (armed_m) begin
      per_e = 20'(gap);
      had = 1;
    end
    armed_m = 1;
    chk("period", period, per_e);
    @(negedge clk);
    #1;
    chk("note_hold", note, note_e);
    chk("locked_hold", locked, locked_e);
    @(negedge clk);
    #1;
    if (had) begin
      c = classify(gap);
      cls_q.push_back(c);
      run = 0;
      i = cls_q.size() - 1;
      while (i >= 0 && cls_q[i] == c) begin
        run++;
        i--;
      end
      nl = (run >= int'(STABLE_N));
      nn = nl ? 4'(c) : note_e;
      if (nl != locked_e || nn != note_e) pulses_e++;
      locked_e = nl;
      note_e = nn;
    end
    chk("note", note, note_e);
    chk("locked", locked, locked_e);
    chk("valid_count", pulses, pulses_e);
  endtask

  task automatic tone_period(input int p);
    edge_step();
    repeat (p / 2 - 5) @(negedge clk);
    tone_in = 1'b0;
    repeat (p - p / 2) @(negedge clk);
    gap = p;
  endtask

  task automatic timeout_step();
    edge_step();
    repeat (15) @(negedge clk);
    tone_in = 1'b0;
    repeat (int'(TIMEOUT) - 18) @(negedge clk);
    #1;
    chk("pre_timeout_locked", locked, locked_e);
    chk("pre_timeout_note", note, note_e);
    @(negedge clk);
    #1;
    silence_m();
    armed_m = 0;
    chk("timeout_note", note, note_e);
    chk("timeout_locked", locked, locked_e);
    chk("timeout_valid_count", pulses, pulses_e);
    repeat (20) @(negedge clk);
  endtask

  task automatic reset_step();
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    note_e = 4'd0;
    locked_e = 1'b0;
    per_e = 20'd0;
    armed_m = 0;
    cls_q.delete();
    chk("async_rst_note", note, 0);
    chk("async_rst_locked", locked, 0);
    chk("async_rst_valid", note_valid, 0);
    chk("async_rst_period", period, 0);
    #9 rst = 1'b0;
    @(negedge clk);
    repeat (5) @(negedge clk);
  endtask

  initial begin
    int base, code, reps, p;
    armed_m = 0;
    gap = 0;
    note_e = 4'd0;
    locked_e = 1'b0;
    per_e = 20'd0;
    pulses_e = 0;

    repeat (3) @(negedge clk);
    #1;
    chk("reset_note", note, 0);
    chk("reset_locked", locked, 0);
    chk("reset_valid", note_valid, 0);
    chk("reset_period", period, 0);
    rst = 1'b0;
    @(negedge clk);

    // A4 lock on the fifth edge
    repeat (5) tone_period(nom(6));
    chk("a4_note", note, 6);
    chk("a4_locked", locked, 1);
    chk("a4_period", period, 454);
    chk("a4_pulses", pulses, 1);

    // F5 lock, then switch to A5
    repeat (6) tone_period(nom(11));
    chk("f5_note", note, 11);
    chk("f5_locked", locked, 1);
    base = pulses;
    repeat (2) tone_period(nom(13));
    chk("a5_unlock_note", note, 11);
    chk("a5_unlock_locked", locked, 0);
    repeat (3) tone_period(nom(13));
    chk("a5_relock_note", note, 13);
    chk("a5_relock_locked", locked, 1);
    chk("a5_pulses", pulses - base, 2);

    // A4 lock, then silence; next edge only arms
    repeat (5) tone_period(nom(6));
    chk("pre_silence_locked", locked, 1);
    timeout_step();
    chk("silence_note", note, 0);
    chk("silence_locked", locked, 0);
    tone_period(nom(6));

    // Edge landing exactly on the timeout is an arming edge
    repeat (4) tone_period(nom(6));
    chk("relock_a4", note, 6);
    tone_period(int'(TIMEOUT));
    tone_period(nom(6));
    chk("tie_timeout_note", note, 0);
    chk("tie_timeout_locked", locked, 0);

    // Steady short period is out of band
    repeat (5) tone_period(80);
    chk("oob_note", note, 15);
    chk("oob_locked", locked, 1);

    // +-1% jitter around A4
    base = pulses;
    for (int k = 0; k < 8; k++) tone_period((k % 2 == 0) ? 449 : 459);
    chk("jitter_note", note, 6);
    chk("jitter_locked", locked, 1);
    chk("jitter_pulses", pulses - base, 2);

    // Asynchronous reset in mid-lock
    reset_step();
    repeat (4) tone_period(nom(6));
    chk("post_rst_unlocked", locked, 0);
    tone_period(nom(6));
    chk("post_rst_note", note, 6);
    chk("post_rst_locked", locked, 1);

    // Random note sequences with jitter and out-of-band bursts
    for (int g = 0; g < 8; g++) begin
      code = int'($urandom_range(1, 15));
      reps = int'($urandom_range(2, 6));
      repeat (reps) begin
        if (code == 15)
          p = ($urandom_range(0, 1) == 0) ? int'($urandom_range(60, 150))
                                          : int'($urandom_range(830, 1500));
        else
          p = nom(code) + int'($urandom_range(0, 6)) - 3;
        tone_period(p);
      end
    end
    tone_period(nom(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
